cp0_regfile: RTL and testbench
==============================

// Module: cp0_regfile
// PURPOSE
//  MIPS32 CP0 state registers, directly downstream of the exception detector.
//  Commits its exception/ERET requests, serves MTC0/MFC0, and runs the Count/Compare timer.
//  Feeds back epc_address, allow_interrupt and interrupt_flag to the exception detector.
// PARAMETERS
//  STATUS_RESET  32'h0040_0000  Status reset value (BEV=1)
//  TIMER_IP_BIT  7              Cause.IP bit ORed with the timer interrupt
// PORTS
//  clk                    in   1   clock
//  rst                    in   1   reset
//  hw_int                 in   6   external interrupt lines, level, active-high
//  cp0_wen                in   1   MTC0 write strobe
//  cp0_waddr              in   5   MTC0 register number (sel ignored)
//  cp0_wdata              in   32  MTC0 data
//  cp0_raddr              in   5   MFC0 register number
//  cp0_rdata              out  32  MFC0 data, combinational from register state
//  cp0_exp_en             in   1   commit exception
//  cp0_exl_clean          in   1   commit ERET
//  cp0_exp_epc            in   32  EPC for committed exception
//  cp0_exp_code           in   5   ExcCode
//  cp0_exp_bad_vaddr      in   32  faulting address
//  cp0_exp_bad_vaddr_wen  in   1   write BadVAddr
//  cp0_exp_bd             in   1   branch-delay flag
//  epc_address            out  32  EPC register value
//  allow_interrupt        out  1   Status.IE & ~Status.EXL
//  interrupt_flag         out  8   Cause.IP[7:0] & Status.IM[7:0]
// BEHAVIOUR
//  Clock and reset: clk is the single clock; rst is asynchronous and active-high.
//  Reset values: BadVAddr(8)=0, Count(9)=0, Compare(11)=0, Status(12)=STATUS_RESET, Cause(13)=0,
//   EPC(14)=0, tick flop=0, timer flag TI=0. All outputs are derived from these values.
//  MFC0: unmapped register numbers read 0. No forwarding: a same-cycle write is not visible.
//  Write masks:
//   Status: only IM[15:8], EXL[1], IE[0] are writable. BEV[22] reads 1. All other bits read 0.
//   Cause: only IP[9:8] is writable.
//   EPC, Compare, Count: fully writable. BadVAddr: not writable by MTC0.
//  Cause.IP[7:2] is registered every cycle as {hw_int[5] | TI, hw_int[4:0]}.
//   Result: an interrupt becomes visible on interrupt_flag 1 cycle after the input.
//  Timer:
//   - A tick flop toggles each cycle. Count increments (mod 2^32) when tick==1.
//   - MTC0 to Count loads wdata and clears tick.
//   - TI is set on the cycle where Count==Compare and tick==1. It stays set (sticky).
//   - MTC0 to Compare clears TI; this clear wins over a same-cycle set.
//  Exception commit (cp0_exp_en=1):
//   - EXL<=1 and Cause.ExcCode[6:2]<=code.
//   - If old EXL==0: EPC<=cp0_exp_epc and Cause.BD[31]<=cp0_exp_bd.
//     Otherwise EPC and BD are held.
//   - If bad_vaddr_wen: BadVAddr<=cp0_exp_bad_vaddr.
//  ERET commit (cp0_exl_clean=1): EXL<=0. No other state changes.
//  Priority: cp0_exp_en > cp0_exl_clean > cp0_wen.
//   An MTC0 in the same cycle as either commit is dropped, because that instruction is squashed.
//   Hardware updates of Cause.IP[7:2] and Count are not blocked by commits.
//  Reset asserted mid-operation: all state returns to reset values immediately (asynchronous),
//   including a pending TI.
// STRUCTURE
//  cp0_pkg holds:
//   - register numbers (CP0_BADVADDR=8, COUNT=9, COMPARE=11, STATUS=12, CAUSE=13, EPC=14)
//   - bit positions (IE, EXL, IM, BEV, IP, EXCCODE, TI=30, BD=31)
//   - Status/Cause write masks
//   - ExcCode constants (INT=0, ADEL=4, ADES=5, SYS=8, BP=9, RI=10, CPU=11, OV=12)
//  Sub-module cp0_timer holds Count, Compare, tick and TI.
//   It exposes count/compare read values and ti_o.
// TESTING
//  1. Release reset, then MFC0 Status=32'h0040_0000, Cause=0, EPC=0.
//     allow_interrupt=0, interrupt_flag=0.
//  2. MTC0 Status=32'h0000_8401, then hw_int[5]=1 -> 1 cycle later Cause.IP7=1,
//     interrupt_flag=8'h80, allow_interrupt=1.
//  3. MTC0 Compare=5, Count=0, then wait -> TI and IP7 set once Count reaches 5
//     (about 10 cycles). MTC0 Compare=100 -> TI=0 the next cycle.
//  4. exp_en with epc=32'h8000_1000, code=5'h0c, bd=1 -> EXL=1, EPC=32'h8000_1000,
//     Cause=32'h8000_0030. A second exp_en with epc=32'h2 -> EPC unchanged.
//  5. exp_en and cp0_wen to EPC in the same cycle -> MTC0 dropped, EPC=exp_epc.
//     Then exl_clean -> EXL=0, EPC held.
//  6. exp_en with bad_vaddr_wen=1 and bad_vaddr=32'h0000_0003 -> BadVAddr=3.
//     Assert rst mid-count -> Count=0 and TI=0 with no clock edge.

Source files
------------

// File: rtl/cp0_pkg.sv
// cp0_pkg: register numbers, bit positions, write masks and ExcCode values for the CP0 block
package cp0_pkg;
    localparam logic [4:0] CP0_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_COUNT    = 5'd9;
    localparam logic [4:0] CP0_COMPARE  = 5'd11;
    localparam logic [4:0] CP0_STATUS   = 5'd12;
    localparam logic [4:0] CP0_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_EPC      = 5'd14;

    localparam int IE_BIT      = 0;
    localparam int EXL_BIT     = 1;
    localparam int IM_LSB      = 8;
    localparam int BEV_BIT     = 22;
    localparam int IP_LSB      = 8;
    localparam int EXCCODE_LSB = 2;
    localparam int TI_BIT      = 30;
    localparam int BD_BIT      = 31;

    localparam logic [31:0] STATUS_WMASK = 32'h0000_ff03;
    localparam logic [31:0] CAUSE_WMASK  = 32'h0000_0300;

    typedef enum logic [4:0] {
        EXC_INT  = 5'd0,
        EXC_ADEL = 5'd4,
        EXC_ADES = 5'd5,
        EXC_SYS  = 5'd8,
        EXC_BP   = 5'd9,
        EXC_RI   = 5'd10,
        EXC_CPU  = 5'd11,
        EXC_OV   = 5'd12
    } exc_code_e;

    function automatic logic [31:0] masked_write(input logic [31:0] old, input logic [31:0] wdata,
                                                 input logic [31:0] mask);
        return (old & ~mask) | (wdata & mask);
    endfunction
endpackage

// File: rtl/cp0_timer.sv
// cp0_timer: Count/Compare timer with half-rate Count and sticky timer interrupt TI
module cp0_timer (
    input  logic        clk,
    input  logic        rst,
    input  logic        count_wen,
    input  logic        compare_wen,
    input  logic [31:0] wdata,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic        ti_o
);
    logic [31:0] count_q, count_d, compare_q, compare_d;
    logic        tick_q, tick_d, ti_q, ti_d;

    // Count advances on odd ticks; a Compare write clears TI even if a match happens this cycle
    always_comb begin
        tick_d    = count_wen ? 1'b0 : ~tick_q;
        count_d   = count_wen ? wdata : count_q + 32'(tick_q);
        compare_d = compare_wen ? wdata : compare_q;
        ti_d      = compare_wen ? 1'b0 : (ti_q | (tick_q && count_q == compare_q));
    end

    // Timer state, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q   <= '0;
            compare_q <= '0;
            tick_q    <= 1'b0;
            ti_q      <= 1'b0;
        end else begin
            count_q   <= count_d;
            compare_q <= compare_d;
            tick_q    <= tick_d;
            ti_q      <= ti_d;
        end
    end

    assign count_o   = count_q;
    assign compare_o = compare_q;
    assign ti_o      = ti_q;
endmodule

// File: rtl/cp0_regfile.sv
// cp0_regfile: MIPS32 CP0 Status/Cause/EPC/BadVAddr registers, exception/ERET commit and MTC0/MFC0
module cp0_regfile
    import cp0_pkg::*;
#(
    parameter logic [31:0] STATUS_RESET = 32'h0040_0000,
    parameter int          TIMER_IP_BIT = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  hw_int,
    input  logic        cp0_wen,
    input  logic [4:0]  cp0_waddr,
    input  logic [31:0] cp0_wdata,
    input  logic [4:0]  cp0_raddr,
    output logic [31:0] cp0_rdata,
    input  logic        cp0_exp_en,
    input  logic        cp0_exl_clean,
    input  logic [31:0] cp0_exp_epc,
    input  logic [4:0]  cp0_exp_code,
    input  logic [31:0] cp0_exp_bad_vaddr,
    input  logic        cp0_exp_bad_vaddr_wen,
    input  logic        cp0_exp_bd,
    output logic [31:0] epc_address,
    output logic        allow_interrupt,
    output logic [7:0]  interrupt_flag
);
    logic [31:0] status_q, status_d, cause_q, cause_d, epc_q, epc_d, badvaddr_q, badvaddr_d;
    logic [31:0] count, compare, cause_rd;
    logic        ti, mtc0_en;

    // An MTC0 alongside a commit belongs to a squashed instruction
    assign mtc0_en = cp0_wen & ~cp0_exp_en & ~cp0_exl_clean;

    cp0_timer u_timer (
        .clk         (clk),
        .rst         (rst),
        .count_wen   (mtc0_en && cp0_waddr == CP0_COUNT),
        .compare_wen (mtc0_en && cp0_waddr == CP0_COMPARE),
        .wdata       (cp0_wdata),
        .count_o     (count),
        .compare_o   (compare),
        .ti_o        (ti)
    );

    // Next-state: hardware IP sampling always, then exception > ERET > MTC0
    always_comb begin
        status_d   = status_q;
        cause_d    = cause_q;
        epc_d      = epc_q;
        badvaddr_d = badvaddr_q;
        cause_d[IP_LSB+2 +: 6] = hw_int | (6'(ti) << (TIMER_IP_BIT - 2));
        if (cp0_exp_en) begin
            status_d[EXL_BIT] = 1'b1;
            cause_d[EXCCODE_LSB +: 5] = cp0_exp_code;
            if (!status_q[EXL_BIT]) begin
                epc_d = cp0_exp_epc;
                cause_d[BD_BIT] = cp0_exp_bd;
            end
            if (cp0_exp_bad_vaddr_wen) badvaddr_d = cp0_exp_bad_vaddr;
        end else if (cp0_exl_clean) begin
            status_d[EXL_BIT] = 1'b0;
        end else if (mtc0_en) begin
            if (cp0_waddr == CP0_STATUS) status_d = masked_write(status_q, cp0_wdata, STATUS_WMASK);
            if (cp0_waddr == CP0_CAUSE) cause_d = masked_write(cause_d, cp0_wdata, CAUSE_WMASK);
            if (cp0_waddr == CP0_EPC) epc_d = cp0_wdata;
        end
    end

    // CP0 register state, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            status_q   <= STATUS_RESET;
            cause_q    <= '0;
            epc_q      <= '0;
            badvaddr_q <= '0;
        end else begin
            status_q   <= status_d;
            cause_q    <= cause_d;
            epc_q      <= epc_d;
            badvaddr_q <= badvaddr_d;
        end
    end

    assign cause_rd = cause_q | (32'(ti) << TI_BIT);
    assign cp0_rdata = cp0_raddr == CP0_BADVADDR ? badvaddr_q :
                       cp0_raddr == CP0_COUNT    ? count      :
                       cp0_raddr == CP0_COMPARE  ? compare    :
                       cp0_raddr == CP0_STATUS   ? status_q   :
                       cp0_raddr == CP0_CAUSE    ? cause_rd   :
                       cp0_raddr == CP0_EPC      ? epc_q      : 32'h0;
    assign epc_address     = epc_q;
    assign allow_interrupt = status_q[IE_BIT] & ~status_q[EXL_BIT];
    assign interrupt_flag  = cause_q[IP_LSB +: 8] & status_q[IM_LSB +: 8];
endmodule

// File: tb/tb_cp0_regfile.sv
// tb_cp0_regfile: table-driven MTC0/MFC0 vectors plus scoreboarded timer/exception sequences
module tb_cp0_regfile;
    timeunit 1ns;
    timeprecision 100ps;
    import cp0_pkg::*;

    logic        clk = 1'b0, rst = 1'b1;
    logic [5:0]  hw_int = '0;
    logic        cp0_wen = 1'b0, cp0_exp_en = 1'b0, cp0_exl_clean = 1'b0;
    logic        cp0_exp_bad_vaddr_wen = 1'b0, cp0_exp_bd = 1'b0;
    logic [4:0]  cp0_waddr = '0, cp0_raddr = '0, cp0_exp_code = '0;
    logic [31:0] cp0_wdata = '0, cp0_exp_epc = '0, cp0_exp_bad_vaddr = '0;
    logic [31:0] cp0_rdata, epc_address;
    logic        allow_interrupt;
    logic [7:0]  interrupt_flag;

    always #5 clk = ~clk;

    cp0_regfile dut (
        .clk                   (clk),
        .rst                   (rst),
        .hw_int                (hw_int),
        .cp0_wen               (cp0_wen),
        .cp0_waddr             (cp0_waddr),
        .cp0_wdata             (cp0_wdata),
        .cp0_raddr             (cp0_raddr),
        .cp0_rdata             (cp0_rdata),
        .cp0_exp_en            (cp0_exp_en),
        .cp0_exl_clean         (cp0_exl_clean),
        .cp0_exp_epc           (cp0_exp_epc),
        .cp0_exp_code          (cp0_exp_code),
        .cp0_exp_bad_vaddr     (cp0_exp_bad_vaddr),
        .cp0_exp_bad_vaddr_wen (cp0_exp_bad_vaddr_wen),
        .cp0_exp_bd            (cp0_exp_bd),
        .epc_address           (epc_address),
        .allow_interrupt       (allow_interrupt),
        .interrupt_flag        (interrupt_flag)
    );

    typedef struct {
        string       nm;
        int          src;
        logic [4:0]  addr;
        logic [31:0] exp;
    } sb_t;

    typedef struct {
        logic        wen;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [4:0]  raddr;
        logic [31:0] exp;
    } vec_t;

    sb_t  sb[$];
    vec_t vecs[10];
    int   errors = 0, checks = 0;

    task automatic push(input string nm, input int src, input logic [4:0] addr, input logic [31:0] exp);
        sb_t e;
        e.nm = nm;
        e.src = src;
        e.addr = addr;
        e.exp = exp;
        sb.push_back(e);
    endtask

    task automatic rd(input string nm, input logic [4:0] addr, input logic [31:0] exp);
        push(nm, 0, addr, exp);
    endtask

    task automatic drain();
        while (sb.size() > 0) begin
            sb_t e;
            logic [31:0] act;
            e = sb.pop_front();
            cp0_raddr = e.addr;
            #0.1;
            act = e.src == 0 ? cp0_rdata : e.src == 1 ? epc_address :
                  e.src == 2 ? 32'(allow_interrupt) : 32'(interrupt_flag);
            checks++;
            if (act !== e.exp) begin
                errors++;
                $display("FAIL %s: got %h expected %h", e.nm, act, e.exp);
            end
        end
    endtask

    task automatic mtc0(input logic [4:0] addr, input logic [31:0] data);
        cp0_wen = 1'b1;
        cp0_waddr = addr;
        cp0_wdata = data;
        @(negedge clk);
        cp0_wen = 1'b0;
    endtask

    task automatic commit(input logic exp, input logic clean, input logic [31:0] epc, input logic [4:0] code,
                          input logic bd, input logic bvw, input logic [31:0] bv,
                          input logic wen, input logic [4:0] wa, input logic [31:0] wd);
        cp0_exp_en = exp;
        cp0_exl_clean = clean;
        cp0_exp_epc = epc;
        cp0_exp_code = code;
        cp0_exp_bd = bd;
        cp0_exp_bad_vaddr_wen = bvw;
        cp0_exp_bad_vaddr = bv;
        cp0_wen = wen;
        cp0_waddr = wa;
        cp0_wdata = wd;
        @(negedge clk);
        cp0_exp_en = 1'b0;
        cp0_exl_clean = 1'b0;
        cp0_exp_bad_vaddr_wen = 1'b0;
        cp0_wen = 1'b0;
    endtask

    initial begin
        vecs[0] = '{1'b1, CP0_STATUS,   32'hffff_ffff, CP0_STATUS,   32'h0040_ff03};
        vecs[1] = '{1'b1, CP0_STATUS,   32'h0000_0000, CP0_STATUS,   32'h0040_0000};
        vecs[2] = '{1'b1, CP0_CAUSE,    32'hffff_ffff, CP0_CAUSE,    32'h0000_0300};
        vecs[3] = '{1'b1, CP0_CAUSE,    32'h0000_0000, CP0_CAUSE,    32'h0000_0000};
        vecs[4] = '{1'b1, CP0_EPC,      32'h1234_5678, CP0_EPC,      32'h1234_5678};
        vecs[5] = '{1'b1, CP0_BADVADDR, 32'hffff_ffff, CP0_BADVADDR, 32'h0000_0000};
        vecs[6] = '{1'b1, 5'd3,         32'hdead_beef, 5'd3,         32'h0000_0000};
        vecs[7] = '{1'b0, 5'd0,         32'h0000_0000, 5'd31,        32'h0000_0000};
        vecs[8] = '{1'b1, CP0_COMPARE,  32'hffff_fff0, CP0_COMPARE,  32'hffff_fff0};
        vecs[9] = '{1'b1, CP0_COUNT,    32'd1000,      CP0_COUNT,    32'd1000};

        repeat (2) @(negedge clk);
        rst = 1'b0;
        rd("rst_status", CP0_STATUS, 32'h0040_0000);
        rd("rst_cause", CP0_CAUSE, 32'h0);
        rd("rst_epc", CP0_EPC, 32'h0);
        rd("rst_badvaddr", CP0_BADVADDR, 32'h0);
        rd("rst_count", CP0_COUNT, 32'h0);
        push("rst_allow", 2, 5'd0, 32'h0);
        push("rst_flag", 3, 5'd0, 32'h0);
        drain();
        mtc0(CP0_COMPARE, 32'hffff_ffff);

        foreach (vecs[i]) begin
            if (vecs[i].wen) mtc0(vecs[i].waddr, vecs[i].wdata);
            else @(negedge clk);
            rd($sformatf("vec%0d", i), vecs[i].raddr, vecs[i].exp);
            drain();
        end
        repeat (2) @(negedge clk);
        rd("count_inc", CP0_COUNT, 32'd1001);
        drain();

        mtc0(CP0_STATUS, 32'h0000_8401);
        rd("status_ie_im", CP0_STATUS, 32'h0040_8401);
        push("allow_on", 2, 5'd0, 32'h1);
        hw_int = 6'b100000;
        push("flag_same_cycle", 3, 5'd0, 32'h0);
        drain();
        @(negedge clk);
        push("flag_ip7", 3, 5'd0, 32'h80);
        rd("cause_ip7", CP0_CAUSE, 32'h0000_8000);
        drain();
        hw_int = '0;
        @(negedge clk);
        push("flag_clear", 3, 5'd0, 32'h0);
        drain();

        mtc0(CP0_COMPARE, 32'd5);
        mtc0(CP0_COUNT, 32'd0);
        repeat (11) @(negedge clk);
        rd("ti_not_yet", CP0_CAUSE, 32'h0);
        drain();
        @(negedge clk);
        rd("ti_set", CP0_CAUSE, 32'h4000_0000);
        drain();
        @(negedge clk);
        rd("ti_ip7", CP0_CAUSE, 32'h4000_8000);
        push("ti_flag", 3, 5'd0, 32'h80);
        drain();
        mtc0(CP0_COMPARE, 32'd100);
        rd("ti_cleared", CP0_CAUSE, 32'h0000_8000);
        drain();
        @(negedge clk);
        rd("ip7_cleared", CP0_CAUSE, 32'h0);
        drain();

        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        mtc0(CP0_COMPARE, 32'hffff_ffff);

        commit(1, 0, 32'h8000_1000, 5'h0c, 1, 0, 32'h0, 0, 5'd0, 32'h0);
        rd("exp_status", CP0_STATUS, 32'h0040_0002);
        rd("exp_epc", CP0_EPC, 32'h8000_1000);
        rd("exp_cause", CP0_CAUSE, 32'h8000_0030);
        push("exp_epc_out", 1, 5'd0, 32'h8000_1000);
        push("exp_allow", 2, 5'd0, 32'h0);
        drain();
        commit(1, 0, 32'h0000_0002, 5'h0c, 0, 0, 32'h0, 0, 5'd0, 32'h0);
        rd("nested_epc", CP0_EPC, 32'h8000_1000);
        rd("nested_cause", CP0_CAUSE, 32'h8000_0030);
        drain();

        commit(0, 1, 32'h0, 5'h0, 0, 0, 32'h0, 1, CP0_STATUS, 32'h0000_0001);
        rd("eret_drop_mtc0", CP0_STATUS, 32'h0040_0000);
        rd("eret_epc", CP0_EPC, 32'h8000_1000);
        drain();
        commit(1, 0, 32'h8000_2000, 5'h08, 0, 0, 32'h0, 1, CP0_EPC, 32'hdead_beef);
        rd("exp_drop_mtc0", CP0_EPC, 32'h8000_2000);
        rd("exp2_cause", CP0_CAUSE, 32'h0000_0020);
        drain();
        commit(0, 1, 32'h0, 5'h0, 0, 0, 32'h0, 0, 5'd0, 32'h0);
        rd("eret2_status", CP0_STATUS, 32'h0040_0000);
        push("eret2_epc", 1, 5'd0, 32'h8000_2000);
        drain();
        commit(1, 1, 32'h0000_0040, 5'h0a, 0, 0, 32'h0, 0, 5'd0, 32'h0);
        rd("exp_over_eret", CP0_STATUS, 32'h0040_0002);
        drain();
        commit(0, 1, 32'h0, 5'h0, 0, 0, 32'h0, 0, 5'd0, 32'h0);

        commit(1, 0, 32'h0000_0100, 5'h04, 0, 1, 32'h0000_0003, 0, 5'd0, 32'h0);
        rd("badvaddr_wr", CP0_BADVADDR, 32'h0000_0003);
        drain();
        commit(1, 0, 32'h0000_0200, 5'h04, 0, 0, 32'h0000_0007, 0, 5'd0, 32'h0);
        rd("badvaddr_hold", CP0_BADVADDR, 32'h0000_0003);
        drain();
        commit(0, 1, 32'h0, 5'h0, 0, 0, 32'h0, 0, 5'd0, 32'h0);

        mtc0(CP0_COMPARE, 32'd501);
        mtc0(CP0_COUNT, 32'd500);
        repeat (6) @(negedge clk);
        rd("pre_rst_cause", CP0_CAUSE, 32'h4000_8010);
        rd("pre_rst_count", CP0_COUNT, 32'd503);
        drain();
        #2;
        rst = 1'b1;
        #0.5;
        rd("async_count", CP0_COUNT, 32'h0);
        rd("async_cause", CP0_CAUSE, 32'h0);
        rd("async_badvaddr", CP0_BADVADDR, 32'h0);
        drain();
        @(negedge clk);
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
